// File: rtl/sm_reg_dumper_pkg.sv
// Shared types and constants for the register dumper.
// Frame length grows to 6 bytes (trailing XOR checksum) when SM_REGDUMP_CHECKSUM_EN is defined.
package sm_reg_dumper_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_CAPTURE = 3'd2,
        S_SEND    = 3'd3,
        S_NEXT    = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    localparam logic [2:0] HDR_TAG = 3'b101;

`ifdef SM_REGDUMP_CHECKSUM_EN
    localparam int FRAME_LEN = 6;
`else
    localparam int FRAME_LEN = 5;
`endif

    localparam int FRAME_W = FRAME_LEN * 8;
    localparam int IDX_W   = 3;

    // Header byte first, then the register value MSB first.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [4:0]  addr,
                                                       input logic [31:0] data);
        logic [39:0] w_base;
        w_base = {HDR_TAG, addr, data};
`ifdef SM_REGDUMP_CHECKSUM_EN
        return {w_base, w_base[39:32] ^ w_base[31:24] ^ w_base[23:16]
                        ^ w_base[15:8] ^ w_base[7:0]};
`else
        return w_base;
`endif
    endfunction

endpackage

// File: rtl/sm_regdump_ser.sv
// Byte serializer: holds one captured frame and shifts it out MSB-byte first
// over a valid/ready link. i_load must only be pulsed while the link is idle.
module sm_regdump_ser
    import sm_reg_dumper_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [FRAME_W-1:0] i_frame,
    input  logic               i_tx_ready,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    output logic               o_last_accepted
);

    // Handshake: a byte moves when o_tx_valid & i_tx_ready at posedge; while
    // stalled, data and valid hold, and valid never drops before acceptance.
    logic [FRAME_W-1:0] r_frame;
    logic               r_valid;
    logic [IDX_W-1:0]   r_idx;
    logic               w_fire;
    logic               w_last;

    assign w_fire = r_valid & i_tx_ready;
    assign w_last = (r_idx == IDX_W'(FRAME_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
        end else if (i_load) begin
            r_frame <= i_frame;
            r_valid <= 1'b1;
            r_idx   <= '0;
        end else if (w_fire) begin
            r_frame <= r_frame << 8;
            r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
            if (w_last) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_tx_data       = r_frame[FRAME_W-1 -: 8];
    assign o_tx_valid      = r_valid;
    assign o_last_accepted = w_fire & w_last;

endmodule

// File: rtl/sm_reg_dumper.sv
// Debug-port master: scans regAddr FIRST_REG..LAST_REG, captures regData and
// streams one frame per register. Optional checksum byte: SM_REGDUMP_CHECKSUM_EN.
module sm_reg_dumper
    import sm_reg_dumper_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int SETTLE    = 1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output state_t      dbg_state
);

    localparam logic [4:0] FIRST_A     = 5'(FIRST_REG);
    localparam logic [4:0] LAST_A      = 5'(LAST_REG);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

    state_t     r_state, w_state_nxt;
    logic [4:0] r_reg_addr, w_reg_addr_nxt;
    logic [3:0] r_settle, w_settle_nxt;
    logic       r_busy, w_busy_nxt;
    logic       w_load;
    logic       w_last_accepted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_reg_addr <= FIRST_A;
            r_settle   <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_reg_addr <= w_reg_addr_nxt;
            r_settle   <= w_settle_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_reg_addr_nxt = r_reg_addr;
        w_settle_nxt   = r_settle;
        w_busy_nxt     = r_busy;
        w_load         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt    = S_SETTLE;
                    w_reg_addr_nxt = FIRST_A;
                    w_settle_nxt   = SETTLE_INIT;
                    w_busy_nxt     = 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_settle == 4'd0) begin
                    w_state_nxt = S_CAPTURE;
                end else begin
                    w_settle_nxt = r_settle - 4'd1;
                end
            end
            S_CAPTURE: begin
                // Serializer frame register doubles as the capture shadow.
                w_load      = 1'b1;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (w_last_accepted) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if (r_reg_addr == LAST_A) begin
                    w_state_nxt = S_FINISH;
                end else begin
                    w_reg_addr_nxt = r_reg_addr + 5'd1;
                    w_settle_nxt   = SETTLE_INIT;
                    w_state_nxt    = S_SETTLE;
                end
            end
            S_FINISH: begin
                w_busy_nxt     = 1'b0;
                w_reg_addr_nxt = FIRST_A;
                w_state_nxt    = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    sm_regdump_ser u_ser (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_load          (w_load),
        .i_frame         (build_frame(r_reg_addr, regData)),
        .i_tx_ready      (tx_ready),
        .o_tx_data       (tx_data),
        .o_tx_valid      (tx_valid),
        .o_last_accepted (w_last_accepted)
    );

    assign busy      = r_busy;
    assign done      = (r_state == S_FINISH);
    assign regAddr   = r_reg_addr;
    assign dbg_state = r_state;

endmodule
